// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one-entry hold buffer, frame FSM and line mux.
// Drives an external serializer that shifts frame data out LSB first.
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             ser_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] ser_pdata,
  output logic             ser_load,
  output logic             ser_en,
  output logic             TX_OUT,
  output logic             busy,
  output logic             tx_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic [WIDTH-1:0] cur_data;
  logic [CW-1:0]    cnt;
  logic             par_q;
  logic             par_en_q;
  logic             accept;
  logic             load;

  assign in_ready  = !hold_valid;
  assign ser_pdata = cur_data;
  assign accept    = Data_Valid && in_ready;
  // A held byte is taken only from IDLE or the last stop cycle,
  // so accept and load can never hit the same buffer entry.
  assign load      = hold_valid && (state == IDLE || state == STOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      cur_data   <= '0;
      cnt        <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        hold_data  <= P_DATA;
        hold_valid <= 1'b1;
      end
      if (load) begin
        cur_data   <= hold_data;
        hold_valid <= 1'b0;
        par_en_q   <= PAR_EN;
        par_q      <= (^hold_data) ^ PAR_TYP;
      end
      if (state == START) begin
        cnt <= '0;
      end else if (state == DATA) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    TX_OUT   = 1'b1;
    ser_load = 1'b0;
    ser_en   = 1'b0;
    busy     = 1'b1;
    tx_done  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (hold_valid) state_nx = START;
      end
      START: begin
        TX_OUT   = 1'b0;
        ser_load = 1'b1;
        state_nx = DATA;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
        if (cnt == LAST) state_nx = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        TX_OUT   = par_q;
        state_nx = STOP;
      end
      STOP: begin
        tx_done  = 1'b1;
        state_nx = hold_valid ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001: Parameter WIDTH, default 8, data bits per frame.
REQ-002: clk  in  1  TX bit clock; one UART bit per clk cycle; all state on rising edge.
REQ-003: rst  in  1  asynchronous, active-high reset.
REQ-004: P_DATA  in  WIDTH  byte to transmit, sampled on accept.
REQ-005: Data_Valid  in  1  request; accepted on an edge where Data_Valid=1 and in_ready=1.
REQ-006: PAR_EN  in  1  1 = parity bit in frame; sampled at frame load.
REQ-007: PAR_TYP  in  1  0 = even, 1 = odd; sampled at frame load.
REQ-008: ser_data  in  1  current data bit from the serializer.
REQ-009: in_ready  out  1  hold buffer empty (=!hold_valid).
REQ-010: ser_pdata  out  WIDTH  registered frame data driven to the serializer.
REQ-011: ser_load  out  1  serializer load strobe (connects to serializer Data_Valid).
REQ-012: ser_en  out  1  serializer enable.
REQ-013: TX_OUT  out  1  serial line.
REQ-014: busy  out  1  frame in progress.
REQ-015: tx_done  out  1  one-cycle pulse, last stop-bit cycle.

Function
REQ-016: One-entry hold buffer (hold_data, hold_valid) plus frame register cur_data driving ser_pdata.
REQ-017: Accept: hold_data<=P_DATA, hold_valid<=1; Data_Valid while in_ready=0 is ignored, no side effect.
REQ-018: FSM states IDLE, START, DATA, PARITY, STOP; one clk per state visit except DATA.
REQ-019: IDLE->START on edge with hold_valid=1; same edge: cur_data<=hold_data, hold_valid<=0, par_en_q<=PAR_EN, par_q<=parity(hold_data, PAR_TYP).
REQ-020: Accept and load never coincide on the same buffer entry: acceptance in IDLE enters START one edge later (1-cycle accept-to-start latency).
REQ-021: START->DATA after one cycle; bit counter cleared to 0.
REQ-022: DATA lasts exactly WIDTH cycles; counter increments each cycle; at count WIDTH-1 -> PARITY if par_en_q else STOP.
REQ-023: PARITY->STOP after one cycle.
REQ-024: STOP, one cycle: if hold_valid -> START with the REQ-019 load (no idle gap); else -> IDLE.
REQ-025: Parity bit: even -> XOR of all data bits; odd -> its inverse.
REQ-026: TX_OUT by state: IDLE 1, START 0, DATA ser_data, PARITY par_q, STOP 1.
REQ-027: ser_load=1 only in START; ser_en=1 only in DATA; data transmitted LSB first.
REQ-028: busy=0 only in IDLE; tx_done=1 only in STOP.
REQ-029: PAR_EN/PAR_TYP changes mid-frame have no effect on the current frame.
REQ-030: Frame length = WIDTH+2 cycles (+1 with parity); back-to-back frames contiguous.
REQ-031: Accept during STOP on the edge leaving STOP for IDLE: byte held, START on following edge.

Reset
REQ-032: rst=1 -> immediately state IDLE, hold_valid=0, counter=0, cur_data=0, par_q=0, par_en_q=0.
REQ-033: Reset outputs: TX_OUT=1, in_ready=1, busy=0, ser_en=0, ser_load=0, tx_done=0, ser_pdata=0.
REQ-034: Reset mid-frame aborts the frame and discards any held byte; no partial completion, no tx_done.

Verification
REQ-035: 0xA5, PAR_EN=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 on consecutive cycles; tx_done on the 10th cycle; busy high for 10 cycles.
REQ-036: 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; frame length 11 cycles.
REQ-037: 0x00 accepted, then 0xFF accepted during first frame -> in_ready=0 after second accept; second START immediately follows first STOP; busy never drops.
REQ-038: Data_Valid with 0x3C while hold full -> ignored; only the held byte is transmitted.
REQ-039: rst asserted in the 4th DATA cycle with a byte held -> TX_OUT=1, busy=0, in_ready=1 immediately; no frame after release until a new accept.
